// File: rtl/i4002_dbg_arb.sv
// Two-requester arbiter for the shared i4002 debug port: serialises byte reads/writes
// and rejects absent chips. Optional read timeout: define I4002_DBG_ARB_TIMEOUT_EN.
module i4002_dbg_arb #(
    parameter int NUM_RAMS       = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req,
    input  logic [1:0]               req_we,
    input  logic [1:0][11:0]         req_addr,
    input  logic [1:0][7:0]          req_wdata,
    output logic [1:0]               ack,
    output logic                     ack_err,
    output logic [7:0]               ack_rdata,
    output logic [2:0][3:0]          dbg_addr,
    output logic [7:0]               dbg_wdata,
    output logic                     dbg_wen,
    output logic                     dbg_ren,
    input  logic [NUM_RAMS-1:0][7:0] dbg_rdata,
    input  logic [NUM_RAMS-1:0]      dbg_rdata_vld,
    output logic                     busy
);

    // state   | meaning
    // IDLE    | waiting for a request, arbitration happens here
    // ISSUE   | one-cycle dbg_wen/dbg_ren strobe with latched address/data
    // WAIT_RD | waiting for any chip to raise read-valid
    // RESP    | one-cycle ack pulse to the granted requester
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    localparam logic [4:0] NUM_RAMS_C = 5'(NUM_RAMS);

    // Elaboration-time sanity check of the configuration.
    if (NUM_RAMS < 1 || NUM_RAMS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("i4002_dbg_arb: NUM_RAMS must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       lat_we;

    logic       win;
    logic [3:0] chip_id;
    logic       decode_err;
    logic [7:0] rd_or;

`ifdef I4002_DBG_ARB_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr;
`endif

    always_comb begin
        win = 1'b0;
        if (req == 2'b11) win = ~last_grant;
        else              win = req[1];
        chip_id    = {req_addr[win][8], req_addr[win][7:5]};
        decode_err = ({1'b0, chip_id} >= NUM_RAMS_C);
    end

    // Several chips answering at once is a system fault; their data is simply ORed.
    always_comb begin
        rd_or = 8'h00;
        for (int i = 0; i < NUM_RAMS; i++) begin
            rd_or = rd_or | (dbg_rdata[i] & {8{dbg_rdata_vld[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            ack        <= 2'b00;
            ack_err    <= 1'b0;
            ack_rdata  <= 8'h00;
            dbg_addr   <= '0;
            dbg_wdata  <= 8'h00;
            dbg_wen    <= 1'b0;
            dbg_ren    <= 1'b0;
`ifdef I4002_DBG_ARB_TIMEOUT_EN
            tmr        <= '0;
`endif
        end else begin
            ack       <= 2'b00;
            ack_err   <= 1'b0;
            ack_rdata <= 8'h00;
            dbg_wen   <= 1'b0;
            dbg_ren   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= win;
                        last_grant <= win;
                        lat_we     <= req_we[win];
                        if (decode_err) begin
                            state   <= RESP;
                            ack     <= win ? 2'b10 : 2'b01;
                            ack_err <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            dbg_addr  <= req_addr[win];
                            dbg_wdata <= req_wdata[win];
                            dbg_wen   <= req_we[win];
                            dbg_ren   <= ~req_we[win];
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        state <= RESP;
                        ack   <= grant ? 2'b10 : 2'b01;
                    end else begin
                        state <= WAIT_RD;
`ifdef I4002_DBG_ARB_TIMEOUT_EN
                        tmr   <= TMR_LOAD;
`endif
                    end
                end
                WAIT_RD: begin
                    if (|dbg_rdata_vld) begin
                        state     <= RESP;
                        ack       <= grant ? 2'b10 : 2'b01;
                        ack_rdata <= rd_or;
                    end
`ifdef I4002_DBG_ARB_TIMEOUT_EN
                    else if (tmr == '0) begin
                        state   <= RESP;
                        ack     <= grant ? 2'b10 : 2'b01;
                        ack_err <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_i4002_dbg_arb.sv
// Randomised scoreboard bench for i4002_dbg_arb with a behavioural model of the
// arbitration order and a byte-array model of the attached chips.
module tb_i4002_dbg_arb;
    localparam int NR = 4;
    localparam int TO = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         req, req_we;
    logic [1:0][11:0]   req_addr;
    logic [1:0][7:0]    req_wdata;
    logic [1:0]         ack;
    logic               ack_err;
    logic [7:0]         ack_rdata;
    logic [2:0][3:0]    dbg_addr;
    logic [7:0]         dbg_wdata;
    logic               dbg_wen, dbg_ren;
    logic [NR-1:0][7:0] dbg_rdata;
    logic [NR-1:0]      dbg_rdata_vld;
    logic               busy;

    always #5 clk = ~clk;

    i4002_dbg_arb #(.NUM_RAMS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen), .dbg_ren(dbg_ren),
        .dbg_rdata(dbg_rdata), .dbg_rdata_vld(dbg_rdata_vld), .busy(busy)
    );

    typedef struct {
        int         idx;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] chip_mem[4096];
    logic [7:0] ref_mem[4096];
    int         model_last = 1;
    int         rd_delay = 0;
    bit         chip_mute = 1'b0;
    bit         fill_ff = 1'b1;
    int         strobe_cnt = 0;
    logic [11:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int chip_of(input logic [11:0] a);
        return int'({a[8], a[7:5]});
    endfunction

    function automatic logic [7:0] noise();
        logic [7:0] n;
        n = 8'($urandom);
        return fill_ff ? 8'hFF : n;
    endfunction

    // Reference model: expected response of one transaction in grant order.
    task automatic push_exp(input int i, input logic we, input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = i;
        e.err = 1'b0;
        e.rdata = 8'h00;
        if (chip_of(a) >= NR) e.err = 1'b1;
        else if (we) ref_mem[a] = d;
        else if (chip_mute) e.err = 1'b1;
        else e.rdata = ref_mem[a];
        sb.push_back(e);
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dbg_wen || dbg_ren) begin
                check("strobe_exclusive", {31'b0, dbg_wen & dbg_ren}, 0);
                check("strobe_busy", {31'b0, busy}, 1);
            end
            if (rst_n && ack != 2'b00) begin
                check("ack_onehot", $countones(ack), 1);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'b0, ack}, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_idx", {30'b0, ack}, 32'(2'b01 << e.idx));
                    check("ack_err", {31'b0, ack_err}, {31'b0, e.err});
                    check("ack_rdata", {24'b0, ack_rdata}, {24'b0, e.rdata});
                end
            end
        end
    end

    // Chip array model: stores writes, answers reads rd_delay cycles after the strobe.
    initial begin
        logic [11:0] a;
        int c;
        forever begin
            @(negedge clk);
            if (dbg_wen) begin
                strobe_cnt++;
                chip_mem[dbg_addr] = dbg_wdata;
                last_waddr = dbg_addr;
                last_wdata = dbg_wdata;
            end
            if (dbg_ren) begin
                strobe_cnt++;
                if (!chip_mute) begin
                    a = dbg_addr;
                    c = chip_of(a);
                    @(posedge clk);
                    repeat (rd_delay) @(posedge clk);
                    #1;
                    for (int i = 0; i < NR; i++) dbg_rdata[i] = (i == c) ? chip_mem[a] : noise();
                    dbg_rdata_vld = NR'(1) << c;
                    @(posedge clk);
                    #1;
                    dbg_rdata_vld = '0;
                    for (int i = 0; i < NR; i++) dbg_rdata[i] = noise();
                end
            end
        end
    end

    // Drives one or two simultaneous requests; each requester drops req the cycle after its ack.
    task automatic run_txn(input logic [1:0] which, input logic [1:0] we,
                           input logic [11:0] a0, input logic [11:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int exp_lat, input bit no_strobe);
        int first, second, cyc, s0;
        logic [1:0] pending, got;
        bit lat_done;
        logic [11:0] aa[2];
        logic [7:0]  dd[2];
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
        @(negedge clk);
        if (which == 2'b11) begin
            first  = (model_last == 0) ? 1 : 0;
            second = 1 - first;
            push_exp(first, we[first], aa[first], dd[first]);
            push_exp(second, we[second], aa[second], dd[second]);
            model_last = second;
        end else begin
            first = which[1] ? 1 : 0;
            push_exp(first, we[first], aa[first], dd[first]);
            model_last = first;
        end
        req_we = we;
        req_addr[0] = a0; req_addr[1] = a1;
        req_wdata[0] = d0; req_wdata[1] = d1;
        req = which;
        pending = which;
        cyc = 0;
        lat_done = 1'b0;
        s0 = strobe_cnt;
        while (pending != 2'b00 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            got = ack & pending;
            if (got != 2'b00) begin
                if (!lat_done && exp_lat > 0) check("latency", cyc, exp_lat);
                lat_done = 1'b1;
                @(posedge clk);
                #1;
                pending = pending & ~got;
                req = req & ~got;
            end
        end
        if (pending != 2'b00) begin
            check("txn_timeout", {30'b0, pending}, 0);
            req = 2'b00;
        end
        if (no_strobe) check("no_strobe", strobe_cnt - s0, 0);
    endtask

    function automatic logic [11:0] gen_addr();
        logic [11:0] a;
        logic [3:0]  chip;
        logic [2:0]  hi;
        logic [4:0]  lo;
        int r;
        r = $urandom_range(0, 5);
        chip = (r == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        hi = 3'($urandom_range(0, 1));
        lo = 5'($urandom_range(0, 3));
        a = {hi, chip[3], chip[2:0], lo};
        return a;
    endfunction

    initial begin
        logic [1:0]  which, we;
        logic [11:0] a0, a1;
        logic [7:0]  d0, d1;
        int lat;
        bit err_single;

        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  which, we;
        logic [11:0] a0, a1;
        logic [7:0]  d0, d1;
        int lat, w;
        bit is_err;

        for (int i = 0; i < 4096; i++) begin
            chip_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        dbg_rdata_vld = '0;
        for (int i = 0; i < NR; i++) dbg_rdata[i] = 8'hFF;
        #12;
        check("reset_outputs", {ack, ack_err, ack_rdata, dbg_addr, dbg_wdata, dbg_wen, dbg_ren, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous reads after reset, then repeated contention for alternation.
        run_txn(2'b11, 2'b00, 12'h023, 12'h040, 8'h00, 8'h00, 3, 1'b0);
        for (int k = 0; k < 3; k++) run_txn(2'b11, 2'b00, 12'h001, 12'h062, 8'h00, 8'h00, 0, 1'b0);

        // Write then read back through chip 1.
        run_txn(2'b01, 2'b01, 12'h023, 12'h000, 8'hA5, 8'h00, 2, 1'b0);
        check("dbg_addr_write", {20'b0, last_waddr}, 32'h023);
        check("dbg_wdata_write", {24'b0, last_wdata}, 32'hA5);
        run_txn(2'b01, 2'b00, 12'h023, 12'h000, 8'h00, 8'h00, 3, 1'b0);

        // Absent chip 8.
        run_txn(2'b10, 2'b00, 12'h000, 12'h100, 8'h00, 8'h00, 1, 1'b1);

        // Chip 2 answers while chip 0 shows 0xFF without valid.
        run_txn(2'b01, 2'b01, 12'h040, 12'h000, 8'h3C, 8'h00, 2, 1'b0);
        rd_delay = 2;
        run_txn(2'b10, 2'b00, 12'h000, 12'h040, 8'h00, 8'h00, 5, 1'b0);

        // Randomised traffic.
        fill_ff = 1'b0;
        for (int k = 0; k < 50; k++) begin
            which = 2'($urandom_range(1, 3));
            we = 2'($urandom_range(0, 3));
            a0 = gen_addr(); a1 = gen_addr();
            d0 = 8'($urandom); d1 = 8'($urandom);
            rd_delay = $urandom_range(0, 3);
            lat = 0;
            is_err = 1'b0;
            if (which != 2'b11) begin
                w = which[1] ? 1 : 0;
                is_err = (chip_of(w == 1 ? a1 : a0) >= NR);
                lat = is_err ? 1 : (we[w] ? 2 : 3 + rd_delay);
            end
            run_txn(which, we, a0, a1, d0, d1, lat, is_err);
        end

`ifdef I4002_DBG_ARB_TIMEOUT_EN
        chip_mute = 1'b1;
        run_txn(2'b01, 2'b00, 12'h020, 12'h000, 8'h00, 8'h00, 2 + TO, 1'b0);
        chip_mute = 1'b0;
`endif

        // Read with no chip answering, then reset while in WAIT_RD.
        chip_mute = 1'b1;
        @(negedge clk);
        req_we = 2'b00; req_addr[1] = 12'h020; req = 2'b10;
        repeat (4) @(negedge clk);
        check("busy_wait_rd", {31'b0, busy}, 1);
`ifndef I4002_DBG_ARB_TIMEOUT_EN
        repeat (20) @(negedge clk);
        check("busy_no_timeout", {31'b0, busy}, 1);
`endif
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        check("reset_mid_txn", {ack, ack_err, ack_rdata, dbg_addr, dbg_wdata, dbg_wen, dbg_ren, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chip_mute = 1'b0;
        model_last = 1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {31'b0, busy}, 0);

        // Fresh traffic after reset restarts with requester 0 winning.
        run_txn(2'b11, 2'b00, 12'h023, 12'h040, 8'h00, 8'h00, 3, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
